// File: rtl/otg_hpi_pkg.sv
// Shared definitions for the OTG HPI bus sequencer: FSM state codes,
// default phase timings and the CY7C67200 HPI register address map.
package otg_hpi_pkg;

    localparam int unsigned DEF_SETUP_CYC   = 2;
    localparam int unsigned DEF_STROBE_CYC  = 4;
    localparam int unsigned DEF_HOLD_CYC    = 2;
    localparam int unsigned DEF_RECOVER_CYC = 4;
    localparam int unsigned DEF_RST_CYC     = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_RST_HOLD     = 3'd0;
    localparam state_t ST_IDLE         = 3'd1;
    localparam state_t ST_SETUP        = 3'd2;
    localparam state_t ST_STROBE       = 3'd3;
    localparam state_t ST_HOLD         = 3'd4;
    localparam state_t ST_RECOVER      = 3'd5;
    localparam state_t ST_WAIT_RELEASE = 3'd6;

    typedef enum logic [1:0] {
        HPI_REG_DATA    = 2'd0,
        HPI_REG_MAILBOX = 2'd1,
        HPI_REG_ADDR    = 2'd2,
        HPI_REG_STATUS  = 2'd3
    } hpi_addr_e;

    // A phase lasting N cycles loads the timer with N-1 on entry and exits when it reaches zero.
    function automatic logic [7:0] phase_load(input int unsigned cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/hpi_phase_timer.sv
// Loadable 8-bit down-counter shared by every sequencer phase; done is
// high while the count sits at zero.
module hpi_phase_timer #(
    parameter logic [7:0] RESET_VAL = 8'd0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic       done_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 8'd0);

endmodule

// File: rtl/otg_hpi_sequencer.sv
// Turns level-style PIO strobes into one timed CY7C67200 HPI bus cycle per
// request, owns the HPI data bus and generates the chip's power-on reset.
module otg_hpi_sequencer
    import otg_hpi_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC  = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
    parameter int unsigned RECOVER_CYC = DEF_RECOVER_CYC,
    parameter int unsigned RST_CYC     = DEF_RST_CYC
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        otg_hpi_cs_export,
    input  logic [1:0]  otg_hpi_address_export,
    input  logic [15:0] otg_hpi_data_out_port,
    input  logic        otg_hpi_r_export,
    input  logic        otg_hpi_w_export,
    output logic [15:0] otg_hpi_data_in_port,
    output logic        hpi_busy,
    output logic [1:0]  OTG_ADDR,
    output logic        OTG_CS_N,
    output logic        OTG_RD_N,
    output logic        OTG_WR_N,
    output logic        OTG_RST_N,
    inout  wire  [15:0] OTG_DATA
);

    state_t      state_q, state_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        rst_n_q, rst_n_d;
    logic [1:0]  addr_q, addr_d;
    logic        is_read_q, is_read_d;
    logic        oe_q, oe_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    logic        tmr_load;
    logic [7:0]  tmr_val;
    logic        tmr_done;
    logic        req_valid;
    logic        released;

    hpi_phase_timer #(
        .RESET_VAL (phase_load(RST_CYC))
    ) u_timer (
        .clk_i      (clk_clk),
        .rst_ni     (reset_reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Exactly one of r/w low; both low is an illegal request and is ignored.
    assign req_valid = !otg_hpi_cs_export && (otg_hpi_r_export ^ otg_hpi_w_export);
    assign released  = otg_hpi_r_export && otg_hpi_w_export;

    always_comb begin
        state_d   = state_q;
        cs_n_d    = cs_n_q;
        rd_n_d    = rd_n_q;
        wr_n_d    = wr_n_q;
        rst_n_d   = rst_n_q;
        addr_d    = addr_q;
        is_read_d = is_read_q;
        oe_d      = oe_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        tmr_load  = 1'b0;
        tmr_val   = 8'd0;

        case (state_q)
            ST_RST_HOLD: begin
                if (tmr_done) begin
                    rst_n_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d    = otg_hpi_address_export;
                    is_read_d = !otg_hpi_r_export;
                    wdata_d   = otg_hpi_data_out_port;
                    oe_d      = otg_hpi_r_export;
                    cs_n_d    = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_val   = phase_load(SETUP_CYC);
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    rd_n_d   = !is_read_q;
                    wr_n_d   = is_read_q;
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(STROBE_CYC);
                    state_d  = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (tmr_done) begin
                    // Read data is captured on the same edge the strobe rises.
                    if (is_read_q) begin
                        rdata_d = OTG_DATA;
                    end
                    rd_n_d   = 1'b1;
                    wr_n_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(HOLD_CYC);
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    cs_n_d   = 1'b1;
                    oe_d     = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = phase_load(RECOVER_CYC);
                    state_d  = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                if (tmr_done) begin
                    state_d = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (released) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= ST_RST_HOLD;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            rst_n_q   <= 1'b0;
            addr_q    <= HPI_REG_DATA;
            is_read_q <= 1'b0;
            oe_q      <= 1'b0;
            wdata_q   <= 16'h0000;
            rdata_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            rst_n_q   <= rst_n_d;
            addr_q    <= addr_d;
            is_read_q <= is_read_d;
            oe_q      <= oe_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign OTG_DATA             = oe_q ? wdata_q : 16'hzzzz;
    assign OTG_ADDR             = addr_q;
    assign OTG_CS_N             = cs_n_q;
    assign OTG_RD_N             = rd_n_q;
    assign OTG_WR_N             = wr_n_q;
    assign OTG_RST_N            = rst_n_q;
    assign otg_hpi_data_in_port = rdata_q;
    assign hpi_busy             = (state_q != ST_IDLE);

endmodule
